intt_gs_butterfly: RTL and testbench

Pipelined Gentleman-Sande (decimation-in-frequency) butterfly for the inverse NTT datapath, the inverse-direction counterpart of the forward Cooley-Tukey butterfly. It accepts one coefficient pair per cycle over a valid/ready handshake and computes a' = (a + b) mod Q and b' = ((a − b)·ω) mod Q. On the final INTT layer it can optionally scale both outputs by N_INV = n⁻¹ mod Q. It sits between the INTT coefficient-memory read port and the write-back port; a sideband tag carries the write-back address.

---
 rtl/intt_gs_butterfly.sv | 102 ++++++++++
 tb/tb_intt_gs_butterfly.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly for the inverse NTT: a' = a+b, b' = (a-b)*w,
// both optionally scaled by N_INV on the last layer. One pair per cycle, valid/ready.
module intt_gs_butterfly #(
   parameter int WIDTH     = 32,
   parameter int Q         = 3329,
   parameter int N_INV     = 3303,
   parameter int TAG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [WIDTH-1:0]     in_twiddle,
   input  logic                 in_scale,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_a,
   output logic [WIDTH-1:0]     out_b,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam logic [WIDTH:0]     Q_X     = (WIDTH+1)'(Q);
   localparam logic [2*WIDTH-1:0] Q_P     = (2*WIDTH)'(Q);
   localparam logic [WIDTH-1:0]   N_INV_W = WIDTH'(N_INV);

   function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [2*WIDTH-1:0] p;
      p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      return WIDTH'(p % Q_P);
   endfunction

   // Stage registers
   logic                 r_v1, r_v2, r_v3;
   logic [WIDTH-1:0]     r_sum1, r_diff1, r_tw1;
   logic                 r_sc1, r_sc2;
   logic [TAG_WIDTH-1:0] r_tag1, r_tag2, r_tag3;
   logic [WIDTH-1:0]     r_sum2, r_prod2;
   logic [WIDTH-1:0]     r_a3, r_b3;

   logic                 w_adv;
   logic [WIDTH:0]       w_sum_raw, w_diff_raw;
   logic [WIDTH-1:0]     w_sum, w_diff, w_prod, w_a3, w_b3;

   // The whole pipe moves as one; it only freezes when the output is held.
   assign w_adv    = !r_v3 || out_ready;
   assign in_ready = w_adv;

   assign w_sum_raw  = {1'b0, in_a} + {1'b0, in_b};
   assign w_diff_raw = {1'b0, in_a} - {1'b0, in_b};
   assign w_sum      = WIDTH'((w_sum_raw >= Q_X) ? (w_sum_raw - Q_X) : w_sum_raw);
   assign w_diff     = WIDTH'((in_a < in_b) ? (w_diff_raw + Q_X) : w_diff_raw);

   assign w_prod = mul_mod(r_diff1, r_tw1);
   assign w_a3   = r_sc2 ? mul_mod(r_sum2, N_INV_W)  : r_sum2;
   assign w_b3   = r_sc2 ? mul_mod(r_prod2, N_INV_W) : r_prod2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_sum1  <= '0;
         r_diff1 <= '0;
         r_tw1   <= '0;
         r_sc1   <= 1'b0;
         r_tag1  <= '0;
         r_v2    <= 1'b0;
         r_sum2  <= '0;
         r_prod2 <= '0;
         r_sc2   <= 1'b0;
         r_tag2  <= '0;
         r_v3    <= 1'b0;
         r_a3    <= '0;
         r_b3    <= '0;
         r_tag3  <= '0;
      end else if (w_adv) begin
         r_v1    <= in_valid;
         r_sum1  <= w_sum;
         r_diff1 <= w_diff;
         r_tw1   <= in_twiddle;
         r_sc1   <= in_scale;
         r_tag1  <= in_tag;
         r_v2    <= r_v1;
         r_sum2  <= r_sum1;
         r_prod2 <= w_prod;
         r_sc2   <= r_sc1;
         r_tag2  <= r_tag1;
         r_v3    <= r_v2;
         r_a3    <= w_a3;
         r_b3    <= w_b3;
         r_tag3  <= r_tag2;
      end
   end

   assign out_valid = r_v3;
   assign out_a     = r_a3;
   assign out_b     = r_b3;
   assign out_tag   = r_tag3;

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Bench for intt_gs_butterfly: fixed vectors, backpressure and reset sequences, and a
// randomized run scored against a plain modular-arithmetic model.
module tb_intt_gs_butterfly;

   localparam longint Q     = 3329;
   localparam longint N_INV = 3303;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0, in_twiddle = '0;
   logic        in_scale = 1'b0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_a, out_b;
   logic [7:0]  out_tag;

   int checks = 0;
   int errors = 0;

   intt_gs_butterfly dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_twiddle(in_twiddle),
      .in_scale(in_scale), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint a;
      longint b;
      logic [7:0] tag;
   } res_t;

   typedef struct {
      longint a, b, w;
      bit s;
      logic [7:0] tag;
      longint ea, eb;
   } vec_t;

   res_t exp_q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic res_t model(input longint a, input longint b, input longint w,
                                  input bit s, input logic [7:0] tag);
      res_t r;
      longint sum, prod;
      sum  = (a + b) % Q;
      prod = (((a - b + Q) % Q) * w) % Q;
      if (s) begin
         sum  = (sum * N_INV) % Q;
         prod = (prod * N_INV) % Q;
      end
      r.a = sum;
      r.b = prod;
      r.tag = tag;
      return r;
   endfunction

   // Scoreboard: inputs and outputs only move at posedge, so negedge sees what the
   // next edge will act on.
   logic        stalled_prev = 1'b0;
   logic [31:0] prev_a, prev_b;
   logic [7:0]  prev_tag;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled_prev = 1'b0;
      end else begin
         res_t e;
         chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
         if (stalled_prev) begin
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_a", out_a, prev_a);
            chk("stall_b", out_b, prev_b);
            chk("stall_tag", out_tag, prev_tag);
         end
         stalled_prev = out_valid && !out_ready;
         prev_a = out_a;
         prev_b = out_b;
         prev_tag = out_tag;
         if (in_valid && in_ready)
            exp_q.push_back(model(in_a, in_b, in_twiddle, in_scale, in_tag));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: got tag %0d expected no result", out_tag);
            end else begin
               e = exp_q.pop_front();
               $display("tx tag=%0d a=%0d b=%0d", out_tag, out_a, out_b);
               chk("sb_a", out_a, e.a);
               chk("sb_b", out_b, e.b);
               chk("sb_tag", out_tag, e.tag);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v);
      in_a = v.a[31:0];
      in_b = v.b[31:0];
      in_twiddle = v.w[31:0];
      in_scale = v.s;
      in_tag = v.tag;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("vec_valid", longint'(out_valid), 1);
      chk("vec_a", out_a, v.ea);
      chk("vec_b", out_b, v.eb);
      chk("vec_tag", out_tag, v.tag);
      step();
      chk("vec_valid_pulse", longint'(out_valid), 0);
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   vec_t vecs[8];

   initial begin
      int acc, c, i, pending;
      logic [7:0] tg;

      vecs[0] = '{a: 5,    b: 3,    w: 1,    s: 0, tag: 8'h11, ea: 8,    eb: 2};
      vecs[1] = '{a: 3,    b: 5,    w: 17,   s: 0, tag: 8'h12, ea: 8,    eb: 3295};
      vecs[2] = '{a: 1,    b: 0,    w: 1,    s: 1, tag: 8'h13, ea: 3303, eb: 3303};
      vecs[3] = '{a: 1,    b: 0,    w: 1,    s: 0, tag: 8'h14, ea: 1,    eb: 1};
      vecs[4] = '{a: 3328, b: 3328, w: 3328, s: 0, tag: 8'h15, ea: 3327, eb: 0};
      vecs[5] = '{a: 0,    b: 3328, w: 3328, s: 0, tag: 8'h16, ea: 3328, eb: 3328};
      vecs[6] = '{a: 3,    b: 5,    w: 17,   s: 1, tag: 8'h17, ea: 3121, eb: 884};
      vecs[7] = '{a: 100,  b: 3000, w: 2000, s: 0, tag: 8'h18, ea: 3100, eb: 2447};

      // Reset state
      #2;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_tag", out_tag, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      foreach (vecs[k]) apply_vec(vecs[k]);

      // Backpressure: tags 0..7 back-to-back, out_ready low for cycles 3..5
      i = 0;
      c = 0;
      while (i < 8 && c < 40) begin
         in_a = 32'($urandom_range(0, 3328));
         in_b = 32'($urandom_range(0, 3328));
         in_twiddle = 32'($urandom_range(0, 3328));
         in_scale = 1'($urandom_range(0, 1));
         in_tag = 8'(i);
         in_valid = 1'b1;
         out_ready = !(c >= 3 && c <= 5);
         #1;
         if (c >= 3 && c <= 5) chk("bp_in_ready_low", longint'(in_ready), 0);
         if (c == 6) chk("bp_in_ready_back", longint'(in_ready), 1);
         acc = in_ready;
         step();
         if (acc != 0) i++;
         c++;
      end
      chk("bp_all_accepted", i, 8);
      drain();

      // Randomized traffic
      pending = 0;
      tg = 8'h40;
      for (int n = 0; n < 400; n++) begin
         if (pending == 0 && $urandom_range(0, 3) != 0) begin
            in_a = 32'($urandom_range(0, 3328));
            in_b = 32'($urandom_range(0, 3328));
            in_twiddle = 32'($urandom_range(0, 3328));
            in_scale = 1'($urandom_range(0, 1));
            in_tag = tg;
            tg = tg + 8'd1;
            in_valid = 1'b1;
            pending = 1;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc = in_valid && in_ready;
         step();
         if (acc != 0) begin
            pending = 0;
            in_valid = 1'b0;
         end
      end
      drain();

      // Reset mid-stream: three pairs in flight
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_a = 32'(10 + k);
         in_b = 32'(k);
         in_twiddle = 32'd1;
         in_scale = 1'b0;
         in_tag = 8'(8'h80 + k);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_out_a", out_a, 0);
      chk("midrst_out_b", out_b, 0);
      chk("midrst_out_tag", out_tag, 0);
      chk("midrst_in_ready", longint'(in_ready), 1);
      exp_q.delete();
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("no_stale_out", longint'(out_valid), 0);
      end
      begin
         vec_t fresh;
         fresh = '{a: 7, b: 2, w: 1, s: 0, tag: 8'h99, ea: 9, eb: 5};
         apply_vec(fresh);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
